// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM-stage controller: write-back select
// encodings, FSM state encoding, MEM/WB payload and the write-back mux.
package mem_access_stage_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned REG_AW             = 5;
  localparam int unsigned MTR_W              = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  localparam logic [MTR_W-1:0] MTR_ALU = 2'b00;
  localparam logic [MTR_W-1:0] MTR_MEM = 2'b01;
  localparam logic [MTR_W-1:0] MTR_PC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic              wen;
    logic [MTR_W-1:0]  mtr;
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
  } wb_t;

  // Encoding 11 falls back to the ALU result.
  function automatic logic [XLEN-1:0] wb_select(input logic [MTR_W-1:0] mtr,
                                                input logic [XLEN-1:0]  alu,
                                                input logic [XLEN-1:0]  mem,
                                                input logic [XLEN-1:0]  pc);
    case (mtr)
      MTR_MEM: return mem;
      MTR_PC:  return pc;
      default: return alu;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus; the stage is the master, the memory the slave.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register; a bubble loads an all-zero (no write-back) entry.
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic bubble,
  input  wb_t  d,
  output wb_t  q
);

  always_ff @(posedge clock) begin
    if (reset || bubble) q <= '0;
    else                 q <= d;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: load/store over req/ack, upstream stall, MEM/WB drive.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inRegWriteEn,
  input  logic [MTR_W-1:0]   inMemtoReg,
  input  logic               inMemWriteEn,
  input  logic               inMemReadEn,
  input  logic [XLEN-1:0]    inpcNext,
  input  logic [XLEN-1:0]    inAluResult,
  input  logic [XLEN-1:0]    inreadData2,
  input  logic [REG_AW-1:0]  inWBAddress,
  mem_access_stage_if.master dmem,
  output logic               stall,
  output logic               mem_error,
  output logic               outRegWriteEn,
  output logic [MTR_W-1:0]   outMemtoReg,
  output logic [REG_AW-1:0]  outWBAddress,
  output logic [XLEN-1:0]    outWBData
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t          state_q, state_d;
  logic            req_q, we_q;
  logic [XLEN-1:0] addr_q, wdata_q, data_q;
  logic            start, ack_hit, tmo_hit, bubble;
  logic            tmo_expire, tmo_q;
  logic [XLEN-1:0] mem_src;
  wb_t             wb_d, wb_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    start   = 1'b0;
    ack_hit = 1'b0;
    tmo_hit = 1'b0;
    mem_src = '0;
    case (state_q)
      ST_IDLE: begin
        if (inMemReadEn || inMemWriteEn) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          start   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall  = 1'b1;
        bubble = 1'b1;
        // Ack in the last counted cycle wins over the timeout.
        if (dmem.ack) begin
          ack_hit = 1'b1;
          state_d = ST_DONE;
        end else if (tmo_expire) begin
          tmo_hit = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        mem_src = data_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory request registers; address/data stay put after completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      req_q   <= 1'b1;
      we_q    <= inMemWriteEn;
      addr_q  <= inAluResult;
      wdata_q <= inreadData2;
    end else if (ack_hit || tmo_hit) begin
      req_q   <= 1'b0;
    end
  end

  // Load data register; stores leave it at zero.
  always_ff @(posedge clock) begin
    if (reset || start)      data_q <= '0;
    else if (ack_hit && !we_q) data_q <= dmem.rdata;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (start) begin
        cnt_q <= '0;
        tmo_q <= 1'b0;
      end else if (state_q == ST_ACCESS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (tmo_hit) begin
        tmo_q <= 1'b1;
        err_q <= 1'b1;
      end
    end
  end

  assign tmo_expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_error  = err_q;
`else
  assign tmo_expire = 1'b0;
  assign tmo_q      = 1'b0;
  assign mem_error  = 1'b0;
`endif

  assign wb_d.wen = inRegWriteEn & ~((state_q == ST_DONE) & tmo_q);
  assign wb_d.mtr = inMemtoReg;
  assign wb_d.wa  = inWBAddress;
  assign wb_d.wd  = wb_select(inMemtoReg, inAluResult, mem_src, inpcNext);

  mem_wb_reg u_mem_wb_reg (
    .clock  (clock),
    .reset  (reset),
    .bubble (bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign outRegWriteEn = wb_q.wen;
  assign outMemtoReg   = wb_q.mtr;
  assign outWBAddress  = wb_q.wa;
  assign outWBData     = wb_q.wd;

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage with an instruction-level
// reference model; covers the MEM_TIMEOUT_EN path when that macro is defined.
module tb_mem_access_stage;

  localparam int unsigned TMO = 16;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [1:0]  mtr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        err;
  } model_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_wen, in_mw, in_mr;
  logic [1:0]  in_mtr;
  logic [31:0] in_pc, in_alu, in_d2;
  logic [4:0]  in_wa;
  logic        stall, mem_error, out_wen;
  logic [1:0]  out_mtr;
  logic [4:0]  out_wa;
  logic [31:0] out_wd;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .clock         (clock),
    .reset         (reset),
    .inRegWriteEn  (in_wen),
    .inMemtoReg    (in_mtr),
    .inMemWriteEn  (in_mw),
    .inMemReadEn   (in_mr),
    .inpcNext      (in_pc),
    .inAluResult   (in_alu),
    .inreadData2   (in_d2),
    .inWBAddress   (in_wa),
    .dmem          (bus.master),
    .stall         (stall),
    .mem_error     (mem_error),
    .outRegWriteEn (out_wen),
    .outMemtoReg   (out_mtr),
    .outWBAddress  (out_wa),
    .outWBData     (out_wd)
  );

  always #5 clock = ~clock;

  int     checks = 0;
  int     failures = 0;
  int     stall_total = 0;
  int     req_rises = 0;
  logic   req_prev = 1'b0;
  model_t m;

  function automatic logic [31:0] wb_ref(input logic [1:0] mtr, input logic [31:0] alu,
                                         input logic [31:0] memv, input logic [31:0] pc);
    if (mtr == 2'b01) return memv;
    if (mtr == 2'b10) return pc;
    return alu;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: compare everything at the falling edge, then advance.
  task automatic step(input logic st);
    @(negedge clock);
    chk("stall",      32'(stall),      32'(st));
    chk("dmem_req",   32'(bus.req),    32'(m.req));
    chk("dmem_we",    32'(bus.we),     32'(m.we));
    chk("dmem_addr",  bus.addr,        m.addr);
    chk("dmem_wdata", bus.wdata,       m.wdata);
    chk("wb_en",      32'(out_wen),    32'(m.wen));
    chk("wb_sel",     32'(out_mtr),    32'(m.mtr));
    chk("wb_addr",    32'(out_wa),     32'(m.wa));
    chk("wb_data",    out_wd,          m.wd);
    chk("mem_error",  32'(mem_error),  32'(m.err));
    if (stall === 1'b1) stall_total++;
    if (bus.req === 1'b1 && req_prev !== 1'b1) req_rises++;
    req_prev = bus.req;
    @(posedge clock);
    #1;
  endtask

  task automatic model_wb(input logic wen, input logic [1:0] mtr, input logic [4:0] wa,
                          input logic [31:0] wd);
    m.wen = wen;
    m.mtr = mtr;
    m.wa  = wa;
    m.wd  = wd;
  endtask

  // Acks outside ACCESS must be ignored, so sprinkle random ones there.
  task automatic noise();
    bus.ack   = 1'($urandom_range(0, 1));
    bus.rdata = $urandom;
  endtask

  task automatic run_instr(input logic wen, input logic [1:0] mtr, input logic mr, input logic mw,
                           input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] d2,
                           input logic [4:0] wa, input int unsigned w, input logic [31:0] rd,
                           input bit tmo);
    int unsigned nacc;
    in_wen = wen; in_mtr = mtr; in_mr = mr; in_mw = mw;
    in_pc = pc; in_alu = alu; in_d2 = d2; in_wa = wa;
    if (!(mr || mw)) begin
      noise();
      step(1'b0);
      model_wb(wen, mtr, wa, wb_ref(mtr, alu, 32'd0, pc));
    end else begin
      noise();
      step(1'b1);
      model_wb(1'b0, 2'b00, 5'd0, 32'd0);
      m.req = 1'b1; m.we = mw; m.addr = alu; m.wdata = d2;
      nacc = tmo ? TMO : w + 1;
      for (int unsigned k = 0; k < nacc; k++) begin
        bus.ack   = (k == nacc - 1) && !tmo;
        bus.rdata = (k == nacc - 1) ? rd : $urandom;
        step(1'b1);
      end
      m.req = 1'b0;
      if (tmo) m.err = 1'b1;
      noise();
      step(1'b0);
      model_wb(wen && !tmo, mtr, wa, wb_ref(mtr, alu, mw ? 32'd0 : rd, pc));
    end
    bus.ack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0;
    reset = 1'b1;
    in_wen = 1'b0; in_mtr = 2'b00; in_mr = 1'b0; in_mw = 1'b0;
    in_pc = '0; in_alu = '0; in_d2 = '0; in_wa = '0;
    bus.ack = 1'b0; bus.rdata = '0;
    m = '0;
    @(posedge clock);
    #1;
    step(1'b0);
    reset = 1'b0;
    chk("reset_req", 32'(bus.req), 32'd0);
    chk("reset_wb_data", out_wd, 32'd0);

    // ALU op: one-cycle latency, no stall
    s0 = stall_total;
    run_instr(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h1234, 32'h0, 5'd5, 0, 32'h0, 1'b0);
    chk("alu_wb_data", out_wd, 32'h0000_1234);
    chk("alu_wb_addr", 32'(out_wa), 32'd5);
    chk("alu_stall_cycles", 32'(stall_total - s0), 32'd0);

    // Load with three wait cycles
    s0 = stall_total; r0 = req_rises;
    run_instr(1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, 5'd7, 3, 32'hCAFE_F00D, 1'b0);
    chk("load_addr", bus.addr, 32'h0000_0100);
    chk("load_we", 32'(bus.we), 32'd0);
    chk("load_stall_cycles", 32'(stall_total - s0), 32'd5);
    chk("load_wb_data", out_wd, 32'hCAFE_F00D);
    chk("load_wb_en", 32'(out_wen), 32'd1);
    chk("load_req_pulses", 32'(req_rises - r0), 32'd1);

    // Store with immediate ack
    s0 = stall_total;
    run_instr(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h40, 32'hA5A5_A5A5, 5'd3, 0, 32'h0, 1'b0);
    chk("store_we", 32'(bus.we), 32'd1);
    chk("store_wdata", bus.wdata, 32'hA5A5_A5A5);
    chk("store_stall_cycles", 32'(stall_total - s0), 32'd2);
    chk("store_wb_en", 32'(out_wen), 32'd0);

    // JAL-style return address
    run_instr(1'b1, 2'b10, 1'b0, 1'b0, 32'h2004, 32'h9999, 32'h0, 5'd1, 0, 32'h0, 1'b0);
    chk("jal_wb_data", out_wd, 32'h0000_2004);

    // Back-to-back load then store
    r0 = req_rises;
    run_instr(1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 5'd9, 1, 32'h1111_2222, 1'b0);
    run_instr(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h204, 32'h3333_4444, 5'd0, 2, 32'h0, 1'b0);
    chk("b2b_req_pulses", 32'(req_rises - r0), 32'd2);

    // Load-and-store together: store wins, memory source reads zero
    run_instr(1'b1, 2'b01, 1'b1, 1'b1, 32'h0, 32'h300, 32'h5555_6666, 5'd4, 1, 32'hFFFF_FFFF, 1'b0);
    chk("both_we", 32'(bus.we), 32'd1);
    chk("both_wb_data", out_wd, 32'd0);

    // Reset in the middle of an access
    in_wen = 1'b1; in_mtr = 2'b01; in_mr = 1'b1; in_mw = 1'b0;
    in_alu = 32'h500; in_d2 = 32'h0; in_wa = 5'd6; in_pc = 32'h0;
    bus.ack = 1'b0;
    step(1'b1);
    model_wb(1'b0, 2'b00, 5'd0, 32'd0);
    m.req = 1'b1; m.we = 1'b0; m.addr = 32'h500; m.wdata = 32'h0;
    step(1'b1);
    reset = 1'b1;
    step(1'b1);
    m = '0;
    reset = 1'b0;
    in_wen = 1'b0; in_mtr = 2'b00; in_mr = 1'b0; in_alu = 32'h0; in_wa = 5'd0;
    bus.ack = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    chk("rst_mid_req", 32'(bus.req), 32'd0);
    chk("rst_mid_wb_en", 32'(out_wen), 32'd0);
    chk("rst_mid_wb_data", out_wd, 32'd0);
    step(1'b0);
    bus.ack = 1'b0;
    run_instr(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h77, 32'h0, 5'd2, 0, 32'h0, 1'b0);
    chk("post_rst_wb_data", out_wd, 32'h0000_0077);

`ifdef MEM_TIMEOUT_EN
    s0 = stall_total;
    run_instr(1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 32'h600, 32'h0, 5'd8, 0, 32'h0, 1'b1);
    chk("tmo_error", 32'(mem_error), 32'd1);
    chk("tmo_wb_en", 32'(out_wen), 32'd0);
    chk("tmo_stall_cycles", 32'(stall_total - s0), 32'd17);
    run_instr(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h88, 32'h0, 5'd2, 0, 32'h0, 1'b0);
    chk("tmo_error_sticky", 32'(mem_error), 32'd1);
`endif

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      int unsigned kind;
      logic mr, mw;
      kind = $urandom_range(0, 3);
      mw = (kind == 3);
      mr = (kind == 2) || (kind == 3 && $urandom_range(0, 3) == 0);
      run_instr(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), mr, mw,
                $urandom, $urandom, $urandom, 5'($urandom), $urandom_range(0, 4),
                $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
